// File: rtl/turn_signal_pkg.sv
// Shared types and constants for the turn-signal sequencer.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } kind_e;

  localparam int MAX_LAMPS = 16;
  localparam int STEP_W    = $clog2(MAX_LAMPS + 1);

  // Thermometer mask with the low k bits set.
  function automatic logic [MAX_LAMPS-1:0] fill_mask(input logic [STEP_W-1:0] k);
    logic [MAX_LAMPS-1:0] m;
    m = {MAX_LAMPS{1'b0}};
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if (i < int'(k)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/turn_signal_seq_prescaler.sv
// Step prescaler: counts 0..DIV-1 and flags the last count as the step tick.
module step_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Wrapping step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {CW{1'b0}};
    end else if (count == LAST) begin
      count <= {CW{1'b0}};
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal / hazard lamp driver with per-step prescaler.
// Optional brake overlay enabled by defining TURN_SIGNAL_BRAKE_EN.
module turn_signal_seq
  import turn_signal_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
`ifdef TURN_SIGNAL_BRAKE_EN
  input  logic             brake,
`endif
  output logic [LAMPS-1:0] l_lamp,
  output logic [LAMPS-1:0] r_lamp,
  output logic             busy
);

  localparam int IDX_W = $clog2(LAMPS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAMPS);
  localparam logic [LAMPS-1:0] ALL_ON   = {LAMPS{1'b1}};
  localparam logic [LAMPS-1:0] ALL_OFF  = {LAMPS{1'b0}};

  kind_e                kind;
  kind_e                kind_nx;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nx;
  logic [LAMPS-1:0]     l_pat;
  logic [LAMPS-1:0]     r_pat;
  logic [LAMPS-1:0]     l_pat_nx;
  logic [LAMPS-1:0]     r_pat_nx;
  logic [MAX_LAMPS-1:0] full_mask;
  logic [LAMPS-1:0]     seq_mask;
  logic                 tick;
  logic                 haz_req;

  step_prescaler #(
    .DIV (STEP_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign haz_req = hazard | (left & right);

  // Next-state selection; the state only advances on a step tick.
  always_comb begin
    kind_nx = kind;
    idx_nx  = idx;
    if (tick) begin
      case (kind)
        IDLE: begin
          if (haz_req) begin
            kind_nx = HAZ;
            idx_nx  = {IDX_W{1'b0}};
          end else if (left) begin
            kind_nx = LEFT;
            idx_nx  = IDX_W'(1);
          end else if (right) begin
            kind_nx = RIGHT;
            idx_nx  = IDX_W'(1);
          end else begin
            kind_nx = IDLE;
            idx_nx  = {IDX_W{1'b0}};
          end
        end
        LEFT, RIGHT: begin
          if (haz_req) begin
            kind_nx = HAZ;
            idx_nx  = {IDX_W{1'b0}};
          end else if (idx == LAST_IDX) begin
            kind_nx = IDLE;
            idx_nx  = {IDX_W{1'b0}};
          end else begin
            kind_nx = kind;
            idx_nx  = idx + IDX_W'(1);
          end
        end
        HAZ: begin
          kind_nx = IDLE;
          idx_nx  = {IDX_W{1'b0}};
        end
        default: begin
          kind_nx = IDLE;
          idx_nx  = {IDX_W{1'b0}};
        end
      endcase
    end else begin
      kind_nx = kind;
      idx_nx  = idx;
    end
  end

  // Lamp pattern of the upcoming state, so the pattern register moves with the state.
  always_comb begin
    full_mask = fill_mask(STEP_W'(idx_nx));
    seq_mask  = full_mask[LAMPS-1:0];
    l_pat_nx  = ALL_OFF;
    r_pat_nx  = ALL_OFF;
    case (kind_nx)
      IDLE: begin
        l_pat_nx = ALL_OFF;
        r_pat_nx = ALL_OFF;
      end
      LEFT: begin
        l_pat_nx = seq_mask;
        r_pat_nx = ALL_OFF;
      end
      RIGHT: begin
        l_pat_nx = ALL_OFF;
        r_pat_nx = seq_mask;
      end
      HAZ: begin
        l_pat_nx = ALL_ON;
        r_pat_nx = ALL_ON;
      end
      default: begin
        l_pat_nx = ALL_OFF;
        r_pat_nx = ALL_OFF;
      end
    endcase
  end

  // State, pattern and busy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind  <= IDLE;
      idx   <= {IDX_W{1'b0}};
      l_pat <= ALL_OFF;
      r_pat <= ALL_OFF;
      busy  <= 1'b0;
    end else begin
      kind  <= kind_nx;
      idx   <= idx_nx;
      l_pat <= l_pat_nx;
      r_pat <= r_pat_nx;
      busy  <= (kind_nx != IDLE);
    end
  end

`ifdef TURN_SIGNAL_BRAKE_EN
  logic l_active;
  logic r_active;

  // The idle gap between repeats of a held turn request still belongs to that
  // side's flashing, so brake does not fill it in.
  assign l_active = (kind == LEFT)  | ((kind == IDLE) & left  & ~haz_req);
  assign r_active = (kind == RIGHT) | ((kind == IDLE) & right & ~haz_req);
  assign l_lamp   = (brake & ~l_active) ? ALL_ON : l_pat;
  assign r_lamp   = (brake & ~r_active) ? ALL_ON : r_pat;
`else
  assign l_lamp = l_pat;
  assign r_lamp = r_pat;
`endif

endmodule

// File: doc/turn_signal_seq.md
TURN_SIGNAL_SEQ -- requirements
Module: turn_signal_seq

Interface
REQ-001 Parameter LAMPS, default 3, lamps per side, legal range 2..16.
REQ-002 Parameter STEP_DIV, default 1, clock cycles per sequence step, legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 left  input  1  left turn request, level-sensitive.
REQ-006 right  input  1  right turn request, level-sensitive.
REQ-007 hazard  input  1  hazard request, level-sensitive.
REQ-008 brake  input  1  brake overlay; present only when BRAKE_EN is defined.
REQ-009 l_lamp  output  LAMPS  left lamps; bit 0 innermost.
REQ-010 r_lamp  output  LAMPS  right lamps; bit 0 innermost.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The prescaler counter shall count 0..STEP_DIV-1 and wrap; step tick is high when the count equals STEP_DIV-1, so STEP_DIV=1 gives a tick every clock.
REQ-013 State transitions shall occur only on clock edges where the step tick is high; otherwise the state holds.
REQ-014 States: IDLE, LEFT(k), RIGHT(k) for k=1..LAMPS, and HAZ.
REQ-015 Hazard request = hazard | (left & right); it has the highest priority in every state.
REQ-016 IDLE: hazard request -> HAZ; else left -> LEFT(1); else right -> RIGHT(1); else stay IDLE.
REQ-017 LEFT(k), k<LAMPS -> LEFT(k+1); LEFT(LAMPS) -> IDLE; RIGHT likewise; left/right changes mid-sequence shall be ignored, so a started sequence completes.
REQ-018 A hazard request at a tick in LEFT(k) or RIGHT(k) shall preempt the sequence -> HAZ.
REQ-019 HAZ -> IDLE unconditionally, so a held hazard alternates all-on/all-off on every step.
REQ-020 Lamp pattern: LEFT(k) drives l_lamp low k bits ones, r_lamp zero; RIGHT(k) mirrors on r_lamp; HAZ drives both all ones; IDLE drives both zero.
REQ-021 The lamp pattern shall be registered, changing on the same edge as the state; a held left request repeats with period (LAMPS+1)*STEP_DIV clocks.

Reset
REQ-022 While reset is high: state IDLE, prescaler count 0, l_lamp=0, r_lamp=0, busy=0, regardless of clk.
REQ-023 Reset asserted mid-sequence or in HAZ shall clear immediately; the first tick after release evaluates requests from IDLE.

Configuration
REQ-024 Macro TURN_SIGNAL_BRAKE_EN: when defined, the brake port exists and brake=1 forces all-ones on every side not showing an active LEFT/RIGHT sequence, combinationally in the same cycle; in HAZ, brake forces both sides all-ones during the off phase.
REQ-025 When TURN_SIGNAL_BRAKE_EN is undefined, the brake port and its logic are absent, and outputs are exactly the registered pattern.

Structure
REQ-026 The package turn_signal_pkg shall hold the state-kind enum (IDLE, LEFT, RIGHT, HAZ), the maximum LAMPS constant (16), and the step-index width.
REQ-027 The prescaler shall be a sub-module named step_prescaler (parameter DIV, outputs tick) instantiated once.
REQ-028 State shall be encoded as kind plus step index of width $clog2(LAMPS+1).

Verification (LAMPS=3, STEP_DIV=1 unless noted)
REQ-029 left held 8 clocks after reset release -> l_lamp 001,011,111,000,001,011,111,000; r_lamp stays 000.
REQ-030 right pulsed 1 clock then low -> r_lamp 001,011,111,000, then stays 000; busy high exactly 3 clocks.
REQ-031 left=right=1 held -> both sides alternate 111/000 each clock; hazard asserted while l_lamp=011 -> next clock both 111.
REQ-032 STEP_DIV=4, left held -> each pattern held 4 clocks; full period 16 clocks.
REQ-033 reset asserted asynchronously between edges while l_lamp=011 -> outputs 000 before the next edge; first post-release tick with right=1 gives r_lamp=001.
REQ-034 LAMPS=5 with TURN_SIGNAL_BRAKE_EN, brake=1 plus left held -> l_lamp 00001..11111,00000 sequence, r_lamp 11111 throughout; brake only -> both 11111.
